psum_ofifo: RTL and testbench

PSUM_OFIFO -- requirements
Module: psum_ofifo

---
 rtl/psum_ofifo.sv | 71 +++++++
 tb/tb_psum_ofifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/psum_ofifo.sv
// psum_ofifo: per-column partial-sum output FIFO that pops complete rows
// Holds COL independent circular buffers of DEPTH words of BW bits. Each column
// accepts its own write request. A row can be popped only when every column has
// at least one word.
// Ports:
//   clk, reset   rising-edge clock; asynchronous active-high reset (pointers only)
//   wr[COL]      per-column write request
//   in[BW*COL]   column k word in bits [(k+1)*BW-1 : k*BW]
//   rd           row pop request, ignored unless o_valid
//   out[BW*COL]  head word of every column (first-word fall-through)
//   o_valid      every column is non-empty
//   o_full       at least one column is full
//   o_ready      ~o_full
//   o_err[1:0]   only with PSUM_OFIFO_ERR_FLAG_EN: sticky {underflow, overflow}
module psum_ofifo #(
    parameter int COL   = 8,
    parameter int BW    = 24,
    parameter int DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [COL-1:0]    wr,
    input  logic [BW*COL-1:0] in,
    input  logic              rd,
    output logic [BW*COL-1:0] out,
    output logic              o_valid,
    output logic              o_full,
`ifdef PSUM_OFIFO_ERR_FLAG_EN
    output logic [1:0]        o_err,
`endif
    output logic              o_ready
);
    localparam int AW = $clog2(DEPTH);

    logic [COL-1:0] empty, full;
    logic           pop;

    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;

    for (genvar k = 0; k < COL; k++) begin : g_col
        logic [AW:0]   wptr, rptr;
        logic [BW-1:0] mem [DEPTH];
        logic          wen;
        assign empty[k] = wptr == rptr;
        assign full[k]  = wptr == {~rptr[AW], rptr[AW-1:0]};
        assign wen      = wr[k] & ~full[k];
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wen) wptr <= wptr + 1'b1;
                if (pop) rptr <= rptr + 1'b1;
            end
        end
        always_ff @(posedge clk) begin
            if (wen) mem[wptr[AW-1:0]] <= in[k*BW +: BW];
        end
        assign out[k*BW +: BW] = mem[rptr[AW-1:0]];
    end

`ifdef PSUM_OFIFO_ERR_FLAG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) o_err <= '0;
        else       o_err <= o_err | {rd & ~o_valid, |(wr & full)};
    end
`endif
endmodule

// File: tb/tb_psum_ofifo.sv
// tb_psum_ofifo: directed self-checking bench for psum_ofifo
module tb_psum_ofifo;
    localparam int COL   = 8;
    localparam int BW    = 24;
    localparam int DEPTH = 64;

    logic              clk = 0;
    logic              reset;
    logic [COL-1:0]    wr;
    logic [BW*COL-1:0] in;
    logic              rd;
    logic [BW*COL-1:0] out;
    logic              o_valid, o_full, o_ready;
`ifdef PSUM_OFIFO_ERR_FLAG_EN
    logic [1:0]        o_err;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    psum_ofifo #(.COL(COL), .BW(BW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr(wr), .in(in), .rd(rd), .out(out),
        .o_valid(o_valid), .o_full(o_full),
`ifdef PSUM_OFIFO_ERR_FLAG_EN
        .o_err(o_err),
`endif
        .o_ready(o_ready)
    );

    function automatic logic [BW*COL-1:0] row(int base, int r);
        logic [BW*COL-1:0] v;
        for (int k = 0; k < COL; k++) v[k*BW +: BW] = BW'(base + r*256 + k);
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [BW*COL-1:0] act, logic [BW*COL-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1; wr = '0; rd = 0; in = '0;
        cyc(); cyc();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", o_full); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
        reset = 0;
        cyc();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b expected 0", o_valid); end
    endtask

    task automatic test_single();
        wr = '1; in = row(32'h100, 0);
        cyc();
        wr = '0;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", o_valid); end
        chk("single_out", out, row(32'h100, 0));
        rd = 1;
        cyc();
        rd = 0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b expected 0", o_valid); end
    endtask

    task automatic test_partial();
        wr = 8'h01;
        for (int r = 0; r < 3; r++) begin
            in = row(32'h2000, r);
            cyc();
            checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL partial_col0_valid: got %b expected 0", o_valid); end
        end
        wr = 8'hFE;
        for (int r = 0; r < 3; r++) begin
            in = row(32'h2000, r);
            cyc();
        end
        wr = '0;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL partial_valid: got %b expected 1", o_valid); end
        for (int r = 0; r < 3; r++) begin
            chk("partial_row", out, row(32'h2000, r));
            rd = 1;
            cyc();
            rd = 0;
        end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL partial_drain_valid: got %b expected 0", o_valid); end
    endtask

    task automatic test_full();
        wr = '1;
        for (int r = 0; r < DEPTH; r++) begin
            in = row(32'h10000, r);
            cyc();
            if (r == DEPTH - 2) begin
                checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL almost_full: got %b expected 0", o_full); end
            end
        end
        checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b expected 1", o_full); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", o_ready); end
        in = row(32'hAB0000, 0); rd = 1;
        cyc();
        wr = '0; rd = 0;
        checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL full_after_pop: got %b expected 0", o_full); end
        for (int r = 1; r < DEPTH; r++) begin
            chk("full_drain_row", out, row(32'h10000, r));
            rd = 1;
            cyc();
            rd = 0;
        end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL full_drained_valid: got %b expected 0", o_valid); end
`ifdef PSUM_OFIFO_ERR_FLAG_EN
        checks++; if (o_err !== 2'b01) begin errors++; $display("FAIL overflow_err: got %b expected 01", o_err); end
`endif
    endtask

    task automatic test_back_to_back();
        wr = '1; in = row(32'h400000, 0);
        cyc();
        for (int r = 0; r < 200; r++) begin
            chk("b2b_row", out, row(32'h400000, r));
            in = row(32'h400000, r + 1); rd = 1;
            cyc();
            checks++; if (o_valid !== 1'b1 || o_full !== 1'b0) begin errors++; $display("FAIL b2b_occupancy: got valid %b full %b expected 1 0", o_valid, o_full); end
        end
        wr = '0;
        chk("b2b_last", out, row(32'h400000, 200));
        cyc();
        rd = 0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained_valid: got %b expected 0", o_valid); end
    endtask

    task automatic test_underflow();
        rd = 1;
        cyc(); cyc();
        rd = 0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL underflow_valid: got %b expected 0", o_valid); end
        wr = '1; in = row(32'h500000, 7);
        cyc();
        wr = '0;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL underflow_refill_valid: got %b expected 1", o_valid); end
        chk("underflow_refill_out", out, row(32'h500000, 7));
        rd = 1;
        cyc();
        rd = 0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL underflow_pop_valid: got %b expected 0", o_valid); end
`ifdef PSUM_OFIFO_ERR_FLAG_EN
        checks++; if (o_err !== 2'b11) begin errors++; $display("FAIL underflow_err: got %b expected 11", o_err); end
`endif
    endtask

    task automatic test_async_reset();
        wr = '1;
        for (int r = 0; r < 10; r++) begin
            in = row(32'h600000, r);
            cyc();
        end
        wr = '0;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL queued_valid: got %b expected 1", o_valid); end
        #1 reset = 1;
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b expected 0", o_valid); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL async_reset_ready: got %b expected 1", o_ready); end
`ifdef PSUM_OFIFO_ERR_FLAG_EN
        checks++; if (o_err !== 2'b00) begin errors++; $display("FAIL async_reset_err: got %b expected 00", o_err); end
`endif
        cyc();
        reset = 0;
        cyc();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid: got %b expected 0", o_valid); end
        wr = '1; in = row(32'h700000, 3);
        cyc();
        wr = '0;
        chk("after_reset_out", out, row(32'h700000, 3));
    endtask

    initial begin
        test_reset();
        test_single();
        test_partial();
        test_full();
        test_back_to_back();
        test_underflow();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
